// File: rtl/gf_pkg.sv
// Shared GF(2^m) Reed-Solomon constants and the syndrome-set type used by the
// syndrome units, this collector and the key-equation solver.
package gf_pkg;

    localparam int ROOTS_NUM  = 8;
    localparam int SYMB_WIDTH = 8;

    typedef logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] synd_vec_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PART,
        OCC_FULL
    } occ_state_t;

    function automatic logic synd_nonzero(input synd_vec_t s);
        return |s;
    endfunction

endpackage

// File: rtl/rs_synd_fifo.sv
// Generic synchronous FIFO with registered storage, wrap-around pointers and
// an occupancy count. Push while full is ignored unless a pop happens on the same edge.
module rs_synd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // When full, a same-edge pop frees the slot at rd_ptr, which equals wr_ptr.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rs_syndrome_collector.sv
// Captures the syndrome set on each codeword's tlast beat, tags it with a
// non-zero flag, and buffers it for the key-equation solver on a valid/ready stream.
module rs_syndrome_collector
    import gf_pkg::*;
#(
    parameter int ROOTS_NUM  = gf_pkg::ROOTS_NUM,
    parameter int SYMB_WIDTH = gf_pkg::SYMB_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 s_tvalid,
    input  logic                                 s_tlast,
    input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] syndromes_i,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] m_tdata,
    output logic                                 m_err_det,
    output logic                                 overflow
);

    localparam int DATA_W = ROOTS_NUM * SYMB_WIDTH;
    localparam int CNT_W  = $clog2(BUF_DEPTH + 1);

    logic              wr_req;
    logic              rd;
    logic              err_bit;
    logic              fifo_push;
    logic [DATA_W:0]   fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    occ_state_t        occ;

    assign wr_req  = s_tvalid & s_tlast;
    assign rd      = m_tvalid & m_tready;
    assign err_bit = |syndromes_i;

    always_comb begin
        occ = OCC_PART;
        if (fifo_count == '0) begin
            occ = OCC_EMPTY;
        end else if (fifo_count == CNT_W'(BUF_DEPTH)) begin
            occ = OCC_FULL;
        end
    end

    // A full buffer only accepts a new set when the head leaves on the same edge.
    assign fifo_push = wr_req & (~fifo_full | rd);

    rs_synd_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (fifo_push),
        .push_data ({syndromes_i, err_bit}),
        .pop       (rd),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            overflow <= 1'b0;
        end else if (wr_req && occ == OCC_FULL && !rd) begin
            overflow <= 1'b1;
        end
    end

    // Head is masked while empty so stale or uninitialised storage never shows.
    assign m_tvalid  = ~fifo_empty;
    assign m_tdata   = m_tvalid ? fifo_head[DATA_W:1] : '0;
    assign m_err_det = m_tvalid & fifo_head[0];

endmodule

// File: tb/tb_rs_syndrome_collector.sv
// Scoreboard bench for rs_syndrome_collector: stimulus queues expected sets,
// a negedge monitor pops and compares on every accepted output beat.
module tb_rs_syndrome_collector;
    import gf_pkg::*;

    typedef struct packed {
        synd_vec_t data;
        logic      err;
    } exp_t;

    logic      aclk = 1'b0;
    logic      areset;
    logic      s_tvalid;
    logic      s_tlast;
    synd_vec_t syndromes_i;
    logic      m_tvalid;
    logic      m_tready;
    synd_vec_t m_tdata;
    logic      m_err_det;
    logic      overflow;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    synd_vec_t set_a, set_b, set_c, set_d, set_e, set_f, set_g, set_h, s3;

    always #5 aclk = ~aclk;

    rs_syndrome_collector #(
        .ROOTS_NUM  (ROOTS_NUM),
        .SYMB_WIDTH (SYMB_WIDTH),
        .BUF_DEPTH  (2)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .syndromes_i (syndromes_i),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_err_det   (m_err_det),
        .overflow    (overflow)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one beat for a cycle, then returns the stream to idle.
    task automatic applyStimulus(input logic valid, input logic last, input synd_vec_t s,
                                 input logic push_exp, input logic exp_err);
        exp_t e;
        s_tvalid    = valid;
        s_tlast     = last;
        syndromes_i = s;
        if (push_exp) begin
            e.data = s;
            e.err  = exp_err;
            exp_q.push_back(e);
        end
        @(posedge aclk);
        #1;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        syndromes_i = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (!areset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_pop: got data %h err %b, expected no beat",
                         m_tdata, m_err_det);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pop_data", m_tdata, e.data);
                checkOutput("pop_err", 64'(m_err_det), 64'(e.err));
            end
        end
    end

    initial begin
        set_a = '0; set_a[0] = 8'h11; set_a[7] = 8'h80;
        set_b = '0; set_b[1] = 8'h22;
        set_c = '0; set_c[2] = 8'h33;
        set_d = '0; set_d[5] = 8'h44;
        set_e = '0; set_e[6] = 8'h01;
        set_f = '0; set_f[4] = 8'hC3;
        set_g = '0;
        set_h = '0; set_h[3] = 8'hFF;
        s3    = '0; s3[3]    = 8'h5A;

        // Reset with a live tlast beat on the inputs
        areset      = 1'b1;
        s_tvalid    = 1'b1;
        s_tlast     = 1'b1;
        syndromes_i = set_a;
        m_tready    = 1'b0;
        idle(2);
        checkOutput("reset_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        checkOutput("reset_tdata", m_tdata, 64'd0);
        checkOutput("reset_err", 64'(m_err_det), 64'd0);
        areset      = 1'b0;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        syndromes_i = '0;

        // Single clean codeword: valid for exactly one cycle
        m_tready = 1'b1;
        idle(5);
        applyStimulus(1'b1, 1'b1, set_g, 1'b1, 1'b0);
        checkOutput("clean_tvalid_n1", 64'(m_tvalid), 64'd1);
        checkOutput("clean_err", 64'(m_err_det), 64'd0);
        idle(1);
        checkOutput("clean_tvalid_n2", 64'(m_tvalid), 64'd0);

        // Corrupted codeword
        applyStimulus(1'b1, 1'b1, s3, 1'b1, 1'b1);
        checkOutput("corrupt_sym3", 64'(m_tdata[3]), 64'h5A);
        checkOutput("corrupt_err", 64'(m_err_det), 64'd1);
        idle(1);

        // Beat without tlast must not capture
        applyStimulus(1'b1, 1'b0, set_h, 1'b0, 1'b0);
        checkOutput("no_tlast_tvalid", 64'(m_tvalid), 64'd0);

        // Backpressure: A and B held, C dropped
        m_tready = 1'b0;
        idle(1);
        applyStimulus(1'b1, 1'b1, set_a, 1'b1, 1'b1);
        idle(2);
        applyStimulus(1'b1, 1'b1, set_b, 1'b1, 1'b1);
        checkOutput("bp_overflow_before", 64'(overflow), 64'd0);
        idle(2);
        applyStimulus(1'b1, 1'b1, set_c, 1'b0, 1'b1);
        checkOutput("bp_overflow_after", 64'(overflow), 64'd1);
        checkOutput("bp_head_held", m_tdata, set_a);
        idle(2);
        checkOutput("bp_head_stable", m_tdata, set_a);
        m_tready = 1'b1;
        idle(2);
        checkOutput("bp_drained_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("bp_overflow_sticky", 64'(overflow), 64'd1);
        checkOutput("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Full with simultaneous pop and write
        areset = 1'b1;
        idle(1);
        areset = 1'b0;
        checkOutput("full_overflow_cleared", 64'(overflow), 64'd0);
        m_tready = 1'b0;
        applyStimulus(1'b1, 1'b1, set_a, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, set_b, 1'b1, 1'b1);
        m_tready = 1'b1;
        applyStimulus(1'b1, 1'b1, set_d, 1'b1, 1'b1);
        checkOutput("full_pop_overflow", 64'(overflow), 64'd0);
        checkOutput("full_pop_head", m_tdata, set_b);
        idle(3);
        checkOutput("full_pop_drained", 64'(m_tvalid), 64'd0);
        checkOutput("full_pop_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation discards the stored set
        m_tready = 1'b0;
        applyStimulus(1'b1, 1'b1, set_f, 1'b0, 1'b1);
        checkOutput("midreset_pre_tvalid", 64'(m_tvalid), 64'd1);
        areset = 1'b1;
        idle(1);
        areset = 1'b0;
        checkOutput("midreset_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("midreset_tdata", m_tdata, 64'd0);
        m_tready = 1'b1;
        applyStimulus(1'b1, 1'b1, set_e, 1'b1, 1'b1);
        idle(2);
        checkOutput("midreset_after_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
